// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the canonical NOP and the fetch entry
// that travels from the prefetch queue to the IF/ID register.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetchEntry_t;

  localparam int ENTRY_W = $bits(fetchEntry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding fetch entries; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo import core_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [ENTRY_W-1:0]      pushData,
  input  logic                    pop,
  output logic [ENTRY_W-1:0]      head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rdPtr;
  logic [AW-1:0]      wrPtr;
  logic               doPush;
  logic               doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited imem requests, in-order response
// tagging, redirect flush with late-response dropping. Optional macro
// FETCH_QUEUE_BYPASS_EN presents a response on the head in the cycle it returns.
module fetch_queue import core_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [XLEN-1:0] fetchPc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   dropCnt;
  logic [XLEN-1:0] tagMem [MAX_OUT];
  logic [TW-1:0]   tagRd;
  logic [TW-1:0]   tagWr;
  logic            accept;
  logic            rspSeen;
  logic            keep;
  logic            bypassHit;
  logic            consume;
  logic            fifoPush;
  logic            fifoPop;
  logic [CW-1:0]   fifoCount;
  logic            fifoFull;
  logic            fifoEmpty;
  fetchEntry_t     rspEntry;
  fetchEntry_t     fifoHead;
  fetchEntry_t     headEntry;

  function automatic logic [TW-1:0] nextTag(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Handshakes: a request transfers on a cycle with imem_req && imem_ready; a
  // response transfers whenever imem_rvalid is high (no back-pressure, in order);
  // the head transfers to decode on instr_valid && !stall_d.
  // Outstanding counts every in-flight request, including ones that will be dropped.
  assign imem_req  = !rst && !redirect && (int'(outstanding) < MAX_OUT) &&
                     (int'(outstanding) + int'(fifoCount) < DEPTH);
  assign imem_addr = fetchPc;
  assign accept    = imem_req && imem_ready;
  assign rspSeen   = imem_rvalid && (outstanding != '0);
  assign keep      = rspSeen && (dropCnt == '0);
  assign rspEntry  = '{instr: imem_rdata, pc: tagMem[tagRd]};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypassHit = keep && fifoEmpty;
`else
  assign bypassHit = 1'b0;
`endif

  assign headEntry   = fifoEmpty ? rspEntry : fifoHead;
  assign instr_valid = !rst && (!fifoEmpty || bypassHit);
  assign instr       = instr_valid ? headEntry.instr : NOP_INSTR;
  assign pc          = instr_valid ? headEntry.pc : '0;
  assign pc_plus4    = pc + 32'd4;
  assign consume     = instr_valid && !stall_d;
  // A bypassed response that decode takes immediately never needs a FIFO slot.
  assign fifoPush    = keep && !redirect && !(bypassHit && consume) && !fifoFull;
  assign fifoPop     = consume && !fifoEmpty && !redirect;

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (fifoPush),
    .pushData (rspEntry),
    .pop      (fifoPop),
    .head     (fifoHead),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      tagRd       <= '0;
      tagWr       <= '0;
    end else if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetchPc     <= {redirect_pc[31:2], 2'b00};
      outstanding <= outstanding - OW'(rspSeen);
      dropCnt     <= outstanding - OW'(rspSeen);
      tagRd       <= '0;
      tagWr       <= '0;
    end else begin
      if (accept) begin
        fetchPc <= fetchPc + 32'd4;
        tagWr   <= nextTag(tagWr);
      end
      if (keep) tagRd <= nextTag(tagRd);
      if (rspSeen && (dropCnt != '0)) dropCnt <= dropCnt - OW'(1);
      outstanding <= outstanding + OW'(accept) - OW'(rspSeen);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tagMem[tagWr] <= fetchPc;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with variable latency and a
// stream reference model (expected buffered addresses, credit rule, fetch PC).
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall_d = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } rsp_t;

  rsp_t        memQ[$];
  logic [31:0] exp_q[$];
  logic [31:0] reqPc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          lastDue = 0;
  int          latMin = 1;
  int          latMax = 1;
  bit          readyRand = 1'b0;
  int          dropped = 0;
  int          firstAcc = -1;
  int          firstVal = -1;
  logic [31:0] firstPc = '1;
  int          checks = 0;
  int          fails = 0;

  logic        nRst = 1'b1;
  logic        nStall = 1'b0;
  logic        nRedirect = 1'b0;
  logic [31:0] nRedirectPc = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: runs at the falling edge with this cycle's inputs stable
  task automatic model();
    bit          kept;
    bit          expValid;
    bit          expReq;
    logic [31:0] headPc;
    logic [31:0] rspAddr;
    int          lat;
    int          due;
    if (rst) begin
      expect_eq("rst_valid", 32'(instr_valid), 32'd0);
      expect_eq("rst_instr", instr, NOP);
      expect_eq("rst_pc", pc, 32'd0);
      expect_eq("rst_pc_plus4", pc_plus4, 32'd4);
      expect_eq("rst_req", 32'(imem_req), 32'd0);
      memQ.delete();
      exp_q.delete();
      epoch++;
      reqPc = RESET_PC;
      return;
    end
    kept     = imem_rvalid && (memQ.size() > 0) && (memQ[0].epoch == epoch);
    rspAddr  = (memQ.size() > 0) ? memQ[0].addr : 32'd0;
    expValid = (exp_q.size() > 0) || (BYPASS && kept);
    headPc   = (exp_q.size() > 0) ? exp_q[0] : rspAddr;
    expReq   = !redirect && (memQ.size() < MAX_OUT) && (memQ.size() + exp_q.size() < DEPTH);

    expect_eq("instr_valid", 32'(instr_valid), 32'(expValid));
    if (expValid) begin
      expect_eq("head_pc", pc, headPc);
      expect_eq("head_instr", instr, memWord(headPc));
      expect_eq("head_pc_plus4", pc_plus4, headPc + 32'd4);
    end else begin
      expect_eq("empty_instr", instr, NOP);
      expect_eq("empty_pc", pc, 32'd0);
      expect_eq("empty_pc_plus4", pc_plus4, 32'd4);
    end
    expect_eq("imem_req", 32'(imem_req), 32'(expReq));
    if (imem_req) expect_eq("imem_addr", imem_addr, reqPc);

    if (instr_valid && firstVal < 0) begin
      firstVal = cyc;
      firstPc  = pc;
    end

    if (imem_rvalid && memQ.size() > 0) begin
      if (!kept) dropped++;
      void'(memQ.pop_front());
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      reqPc = redirect_pc;
    end else begin
      if (kept) exp_q.push_back(rspAddr);
      if (expValid && !stall_d && exp_q.size() > 0) void'(exp_q.pop_front());
      if (imem_req && imem_ready) begin
        lat = $urandom_range(latMin, latMax);
        due = (cyc + lat > lastDue) ? cyc + lat : lastDue + 1;
        lastDue = due;
        memQ.push_back('{addr: imem_addr, epoch: epoch, due: due});
        reqPc = reqPc + 32'd4;
        if (firstAcc < 0) firstAcc = cyc;
      end
    end
  endtask

  // driver: applies the queued inputs just after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst         = nRst;
    stall_d     = nStall;
    redirect    = nRedirect;
    redirect_pc = nRedirectPc;
    imem_ready  = readyRand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!nRst && memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(memQ[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    @(negedge clk);
    model();
  endtask

  initial begin
    logic [31:0] holdPc;
    logic [31:0] holdInstr;
    int n;

    repeat (3) cycle();
    nRst = 1'b0;
    cycle();
    expect_eq("post_rst_req", 32'(imem_req), 32'd1);
    expect_eq("post_rst_addr", imem_addr, RESET_PC);
    expect_eq("post_rst_valid", 32'(instr_valid), 32'd0);
    repeat (5) cycle();
    expect_eq("first_latency", 32'(firstVal - firstAcc), BYPASS ? 32'd1 : 32'd2);
    expect_eq("first_pc", firstPc, RESET_PC);

    // stall held 10 cycles: queue fills to DEPTH, head frozen
    nStall = 1'b1;
    cycle();
    holdPc = pc;
    holdInstr = instr;
    repeat (9) cycle();
    expect_eq("stall_fill", 32'(exp_q.size()), 32'(DEPTH));
    expect_eq("stall_req_low", 32'(imem_req), 32'd0);
    expect_eq("stall_pc_hold", pc, holdPc);
    expect_eq("stall_instr_hold", instr, holdInstr);

    // redirect with two requests in flight
    nStall = 1'b0;
    latMin = 3;
    latMax = 3;
    n = 0;
    while (!(memQ.size() == 2 && memQ[0].due > cyc + 1) && n < 50) begin
      cycle();
      n++;
    end
    expect_eq("wait_two_outstanding", 32'(memQ.size() == 2), 32'd1);
    dropped = 0;
    nRedirect = 1'b1;
    nRedirectPc = 32'h0000_0100;
    cycle();
    nRedirect = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!instr_valid && n < 30);
    expect_eq("redir_valid", 32'(instr_valid), 32'd1);
    expect_eq("redir_pc", pc, 32'h0000_0100);
    expect_eq("redir_pc_plus4", pc_plus4, 32'h0000_0104);
    expect_eq("redir_dropped", 32'(dropped), 32'd2);

    // redirect and pop in the same cycle with three entries buffered
    latMin = 1;
    latMax = 1;
    nStall = 1'b1;
    n = 0;
    while (exp_q.size() != 3 && n < 30) begin
      cycle();
      n++;
    end
    expect_eq("wait_count3", 32'(exp_q.size()), 32'd3);
    nStall = 1'b0;
    nRedirect = 1'b1;
    nRedirectPc = 32'h0000_0200;
    cycle();
    nRedirect = 1'b0;
    cycle();
    expect_eq("rp_valid_after", 32'(instr_valid), 32'd0);
    expect_eq("rp_pc_after", pc, 32'd0);
    repeat (6) cycle();

    // random traffic with a forced redirect near the top of the address space
    readyRand = 1'b1;
    latMax = 3;
    for (int i = 0; i < 800; i++) begin
      nStall = ($urandom_range(0, 9) < 3);
      nRedirect = ($urandom_range(0, 39) == 0);
      nRedirectPc = $urandom() & 32'hFFFF_FFFC;
      if (i == 400) begin
        nRedirect = 1'b1;
        nStall = 1'b0;
        nRedirectPc = 32'hFFFF_FFF0;
      end else if (i > 400 && i < 440) begin
        nRedirect = 1'b0;
      end
      cycle();
    end
    readyRand = 1'b0;
    nStall = 1'b0;
    nRedirect = 1'b0;
    latMax = 1;
    repeat (20) cycle();

    // reset mid-stream with two entries buffered
    nStall = 1'b1;
    n = 0;
    while (exp_q.size() != 2 && n < 30) begin
      cycle();
      n++;
    end
    expect_eq("wait_count2", 32'(exp_q.size()), 32'd2);
    nRst = 1'b1;
    cycle();
    nRst = 1'b0;
    nStall = 1'b0;
    cycle();
    expect_eq("mrst_valid", 32'(instr_valid), 32'd0);
    expect_eq("mrst_req", 32'(imem_req), 32'd1);
    expect_eq("mrst_addr", imem_addr, RESET_PC);
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MAX_OUT, default 2, maximum outstanding imem requests.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port stall_d  in  1  decode stall; head not consumed.
REQ-007 SHALL have port redirect  in  1  taken branch/jump/jalr resolved in EX.
REQ-008 SHALL have port redirect_pc  in  32  new fetch target.
REQ-009 SHALL have port imem_req  out  1  request valid.
REQ-010 SHALL have port imem_addr  out  32  word-aligned request address.
REQ-011 SHALL have port imem_ready  in  1  memory accepts request this cycle.
REQ-012 SHALL have port imem_rvalid  in  1  response valid; responses return in request order.
REQ-013 SHALL have port imem_rdata  in  32  response instruction.
REQ-014 SHALL have port instr_valid  out  1  head entry valid for IF/ID register.
REQ-015 SHALL have port instr  out  32  head instruction.
REQ-016 SHALL have port pc  out  32  head instruction address.
REQ-017 SHALL have port pc_plus4  out  32  pc + 4, modulo 2^32.

Function
REQ-018 SHALL hold fetch PC; request accepted when imem_req && imem_ready; fetch PC += 4 on accept.
REQ-019 SHALL assert imem_req only when outstanding < MAX_OUT and outstanding + fifo_count < DEPTH (credit rule; FIFO never overflows).
REQ-020 SHALL record each accepted address in order; a kept response pushes {imem_rdata, its address}.
REQ-021 SHALL pop the head when instr_valid && !stall_d; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 SHALL, when the FIFO is empty, drive instr_valid=0, instr=32'h0000_0013 (NOP), pc=0, pc_plus4=4.
REQ-023 SHALL, on redirect, next cycle: fetch PC=redirect_pc, FIFO empty, instr_valid=0; all requests outstanding at the redirect edge SHALL be discarded on return (drop counter loaded with outstanding count, decremented per rvalid).
REQ-024 SHALL suppress imem_req in the redirect cycle; the first request to redirect_pc SHALL issue the following cycle.
REQ-025 SHALL give redirect priority over same-cycle pop, push and accept; a request accepted in the redirect cycle does not occur (REQ-024).
REQ-026 SHALL, with stall_d held, keep instr/pc stable and continue prefetching until credit exhausted.
REQ-027 SHALL wrap FIFO pointers modulo DEPTH; fetch PC wraps 32'hFFFF_FFFC -> 0.
REQ-028 SHALL have response-to-instr_valid latency of 1 cycle (FIFO registered) unless REQ-034 applies.

Reset
REQ-029 SHALL on rst: fetch PC=RESET_PC, FIFO count=0, outstanding=0, drop counter=0, imem_req=0.
REQ-030 SHALL drive outputs per REQ-022 during and one cycle after rst.
REQ-031 SHALL ignore imem_rvalid during rst; responses to requests issued before a mid-operation rst are the memory's responsibility to cancel.
REQ-032 SHALL issue first request to RESET_PC the cycle after rst deasserts.

Configuration
REQ-033 SHALL use macro FETCH_QUEUE_BYPASS_EN.
REQ-034 SHALL, with macro defined, present a kept response combinationally on instr/pc/instr_valid when FIFO empty (0-cycle latency); if not popped (stall_d) it SHALL be written into the FIFO.
REQ-035 SHALL, without macro, always route responses through the FIFO (REQ-028).

Structure
REQ-036 SHALL place XLEN=32, NOP_INSTR=32'h0000_0013 and the fetch entry struct {instr, pc} in shared package core_pkg.
REQ-037 SHALL instantiate one sub-module fetch_fifo (synchronous FIFO, count, full/empty); credit, address-tag and drop logic stay in fetch_queue.

Verification
REQ-038 Reset, imem_ready=1, rvalid 1 cycle after accept -> requests to 0x0,0x4,0x8...; instr_valid first high 2 cycles after first accept (1 with bypass), pc=0x0.
REQ-039 stall_d held 10 cycles, DEPTH=4 -> exactly 4 entries buffered, imem_req low afterwards, instr/pc unchanged.
REQ-040 redirect to 0x100 with 2 outstanding -> both late responses dropped, next instr_valid shows pc=0x100, pc_plus4=0x104.
REQ-041 redirect and pop in same cycle with FIFO count 3 -> count 0 next cycle, no entry from old path emitted.
REQ-042 imem_ready toggling randomly, rvalid latency 1..3 -> pc sequence strictly +4, no loss, no duplicate, no overflow.
REQ-043 rst asserted mid-stream with FIFO count 2 -> instr_valid=0, next request address RESET_PC.
